// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encoding and counter sizing for the bit-serial subtractor
package serial_sub_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // A 1-bit operand still needs a 1-bit counter, so clamp the log at 1.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - single-bit combinational full subtractor
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial a - b - bin with start/done handshake
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic           br_q, br_d;
    logic           bout_q, bout_d;

    logic             fs_d;
    logic             fs_bout;
    logic [WIDTH-1:0] res_shift;

    full_subtractor u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    always_comb begin
        res_shift            = res_q >> 1;
        res_shift[WIDTH-1]   = fs_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_shift;
                br_d  = fs_bout;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    diff_d  = res_shift;
                    bout_d  = fs_bout;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign busy = (state_q == ST_BUSY);
    assign done = (state_q == ST_DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized and directed checks of serial_subtractor at widths 1, 5, 8, 16
module tb_serial_subtractor;

    logic clk;
    logic rst;

    logic        st0, st1, st2, st3;
    logic [0:0]  a0, b0;
    logic [4:0]  a1, b1;
    logic [7:0]  a2, b2;
    logic [15:0] a3, b3;
    logic        bi0, bi1, bi2, bi3;
    logic        bz0, bz1, bz2, bz3;
    logic        dn0, dn1, dn2, dn3;
    logic [0:0]  df0;
    logic [4:0]  df1;
    logic [7:0]  df2;
    logic [15:0] df3;
    logic        bo0, bo1, bo2, bo3;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .start(st0), .a(a0), .b(b0), .bin(bi0),
        .busy(bz0), .done(dn0), .diff(df0), .bout(bo0));
    serial_subtractor #(.WIDTH(5)) u_w5 (
        .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .bin(bi1),
        .busy(bz1), .done(dn1), .diff(df1), .bout(bo1));
    serial_subtractor #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .start(st2), .a(a2), .b(b2), .bin(bi2),
        .busy(bz2), .done(dn2), .diff(df2), .bout(bo2));
    serial_subtractor #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .start(st3), .a(a3), .b(b3), .bin(bi3),
        .busy(bz3), .done(dn3), .diff(df3), .bout(bo3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int wid(input int k);
        case (k)
            0: return 1;
            1: return 5;
            2: return 8;
            default: return 16;
        endcase
    endfunction

    task automatic drive(input int k, input logic [15:0] av, input logic [15:0] bv,
                         input logic bv_in, input logic sv);
        case (k)
            0: begin a0 = av[0:0]; b0 = bv[0:0]; bi0 = bv_in; st0 = sv; end
            1: begin a1 = av[4:0]; b1 = bv[4:0]; bi1 = bv_in; st1 = sv; end
            2: begin a2 = av[7:0]; b2 = bv[7:0]; bi2 = bv_in; st2 = sv; end
            default: begin a3 = av; b3 = bv; bi3 = bv_in; st3 = sv; end
        endcase
    endtask

    function automatic logic is_busy(input int k);
        case (k)
            0: return bz0;
            1: return bz1;
            2: return bz2;
            default: return bz3;
        endcase
    endfunction

    function automatic logic is_done(input int k);
        case (k)
            0: return dn0;
            1: return dn1;
            2: return dn2;
            default: return dn3;
        endcase
    endfunction

    // {bout, diff} packed as a single integer with bout at bit position WIDTH.
    function automatic int res_of(input int k);
        case (k)
            0: return (int'(bo0) << 1)  | int'(df0);
            1: return (int'(bo1) << 5)  | int'(df1);
            2: return (int'(bo2) << 8)  | int'(df2);
            default: return (int'(bo3) << 16) | int'(df3);
        endcase
    endfunction

    function automatic int model(input int w, input int av, input int bv, input int bi);
        int mask;
        mask = (1 << w) - 1;
        return ((av & mask) - (bv & mask) - bi) & ((1 << (w + 1)) - 1);
    endfunction

    task automatic run_op(input int k, input int av, input int bv, input int bi,
                          input string tag, output int res);
        int w, n, nb, both;
        logic seen;
        w = wid(k);
        drive(k, 16'(av), 16'(bv), bi[0], 1'b1);
        @(posedge clk); #1;
        drive(k, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        nb = is_busy(k) ? 1 : 0;
        n = 0;
        both = 0;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            @(posedge clk); #1;
            n++;
            if (is_busy(k) && is_done(k)) both++;
            if (is_done(k)) seen = 1'b1;
            else if (is_busy(k)) nb++;
        end
        check_val({tag, "_done_seen"}, int'(seen), 1);
        check_val({tag, "_latency"}, n, w);
        check_val({tag, "_busy_cycles"}, nb, w);
        check_val({tag, "_busy_and_done"}, both, 0);
        res = res_of(k);
        check_val({tag, "_result"}, res, model(w, av, bv, bi));
        @(posedge clk); #1;
        check_val({tag, "_done_pulse"}, int'(is_done(k)), 0);
    endtask

    initial begin
        int r, n, pulses;
        logic seen;

        rst = 1'b1;
        for (int k = 0; k < 4; k++) drive(k, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("reset_busy_w%0d", wid(k)), int'(is_busy(k)), 0);
            check_val($sformatf("reset_done_w%0d", wid(k)), int'(is_done(k)), 0);
            check_val($sformatf("reset_result_w%0d", wid(k)), res_of(k), 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(2, 'h5A, 'h3C, 0, "w8_5a_3c", r);
        check_val("w8_5a_3c_const", r, 'h01E);
        run_op(2, 'h00, 'h01, 0, "w8_00_01", r);
        check_val("w8_00_01_const", r, 'h1FF);
        run_op(2, 'h10, 'h10, 1, "w8_10_10_b1", r);
        check_val("w8_10_10_b1_const", r, 'h1FF);
        run_op(2, 'hFF, 'h00, 1, "w8_ff_00_b1", r);
        check_val("w8_ff_00_b1_const", r, 'h0FE);

        for (int i = 0; i < 8; i++) begin
            run_op(0, (i >> 2) & 1, (i >> 1) & 1, i & 1, $sformatf("w1_tt%0d", i), r);
            if (i == 3) check_val("w1_0_1_1_const", r, 'b10);
        end

        // A start pulse mid-operation with different operands must be ignored.
        drive(2, 16'h5A, 16'h3C, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(2, 16'h5A, 16'h3C, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        drive(2, 16'hFF, 16'h00, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(2, 16'hFF, 16'h00, 1'b0, 1'b0);
        n = 0;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            @(posedge clk); #1;
            n++;
            if (is_done(2)) seen = 1'b1;
        end
        check_val("ignore_done_seen", int'(seen), 1);
        check_val("ignore_result", res_of(2), 'h01E);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_val($sformatf("hold_result_%0d", i), res_of(2), 'h01E);
            check_val($sformatf("hold_idle_busy_%0d", i), int'(is_busy(2)), 0);
        end

        // Reset in the 4th BUSY cycle discards the operation without a done.
        drive(2, 16'h33, 16'h11, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(2, 16'h33, 16'h11, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_val("pre_reset_busy", int'(is_busy(2)), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("midrst_busy", int'(is_busy(2)), 0);
        check_val("midrst_done", int'(is_done(2)), 0);
        check_val("midrst_result", res_of(2), 0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (is_done(2) || is_busy(2)) pulses++;
        end
        check_val("midrst_no_done", pulses, 0);
        run_op(2, 'h80, 'h01, 0, "w8_80_01", r);
        check_val("w8_80_01_const", r, 'h07F);

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 1000; i++) begin
                run_op(k, int'($urandom & 32'hFFFF), int'($urandom & 32'hFFFF),
                       int'($urandom & 32'h1), $sformatf("rnd_w%0d_%0d", wid(k), i), r);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
